// File: rtl/block_checker.sv
// Streaming begin/end balance checker: one ASCII character per clock, result = balanced so far.
// Optional BLOCK_CHECKER_DEPTH_OUT_EN exposes the depth counter and sticky fail flag as ports.
//
// state | meaning
// SEP   | last byte was a separator (or just out of reset)
// B     | word so far is "b"
// BE    | word so far is "be"
// BEG   | word so far is "beg"
// BEGI  | word so far is "begi"
// BEGIN | word so far is exactly "begin" (counted tentatively)
// E     | word so far is "e"
// EN    | word so far is "en"
// END   | word so far is exactly "end" (counted tentatively)
// OTHER | current word can no longer be a keyword
module block_checker #(
    parameter int DEPTH_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in,
    output logic                      result
`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
    ,
    output logic signed [DEPTH_W-1:0] depth,
    output logic                      fail
`endif
);

    typedef enum logic [3:0] {
        SEP   = 4'd0,
        B     = 4'd1,
        BE    = 4'd2,
        BEG   = 4'd3,
        BEGI  = 4'd4,
        BEGIN = 4'd5,
        E     = 4'd6,
        EN    = 4'd7,
        END   = 4'd8,
        OTHER = 4'd9
    } state_t;

    localparam logic signed [DEPTH_W-1:0] DEPTH_MAX = {1'b0, {(DEPTH_W-1){1'b1}}};
    localparam logic signed [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t                      state_q, state_n;
    logic signed [DEPTH_W-1:0]   depth_q, depth_n;
    logic                        fail_q, fail_n;
    logic                        result_q;
    logic                        is_letter;
    logic [7:0]                  lc;

    always_comb begin
        is_letter = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
        lc        = in | 8'h20;

        state_n = state_q;
        if (!is_letter) begin
            state_n = SEP;
        end else begin
            case (state_q)
                SEP:     state_n = (lc == "b") ? B : ((lc == "e") ? E : OTHER);
                B:       state_n = (lc == "e") ? BE    : OTHER;
                BE:      state_n = (lc == "g") ? BEG   : OTHER;
                BEG:     state_n = (lc == "i") ? BEGI  : OTHER;
                BEGI:    state_n = (lc == "n") ? BEGIN : OTHER;
                E:       state_n = (lc == "n") ? EN    : OTHER;
                EN:      state_n = (lc == "d") ? END   : OTHER;
                default: state_n = OTHER;
            endcase
        end
    end

    // Keywords are counted the moment they complete and undone if the word keeps going,
    // so result is right on the last letter without waiting for the separator.
    always_comb begin
        depth_n = depth_q;
        fail_n  = fail_q;
        if (!fail_q) begin
            if ((state_q == BEGI && state_n == BEGIN) || (state_q == END && is_letter)) begin
                if (depth_q == DEPTH_MAX) begin
                    fail_n = 1'b1;
                end else begin
                    depth_n = depth_q + DEPTH_ONE;
                end
            end else if ((state_q == BEGIN && is_letter) || (state_q == EN && state_n == END)) begin
                depth_n = depth_q - DEPTH_ONE;
            end else if (state_q == END && !is_letter && depth_q[DEPTH_W-1]) begin
                fail_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEP;
            depth_q  <= '0;
            fail_q   <= 1'b0;
            result_q <= 1'b1;
        end else begin
            state_q  <= state_n;
            depth_q  <= depth_n;
            fail_q   <= fail_n;
            result_q <= (depth_n == '0) && !fail_n;
        end
    end

    assign result = result_q;

`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
    assign depth = depth_q;
    assign fail  = fail_q;
`endif

endmodule

// File: tb/tb_block_checker.sv
// Scoreboard bench for block_checker: word-level reference model, directed and random streams.
module tb_block_checker;

    localparam int DW    = 4;
    localparam int D_MAX = (1 << (DW - 1)) - 1;

    typedef struct {
        bit  res;
        int  dep;
        bit  fl;
        byte ch;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           din = 8'h20;
    logic                 result;
`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
    logic signed [DW-1:0] depth;
    logic                 fail;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    // Reference model: committed depth of finished words plus the current word text.
    int    m_cd;
    string m_w;
    bit    m_f;
    int    m_frozen;

    block_checker #(.DEPTH_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (din),
        .result (result)
`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
        ,
        .depth  (depth),
        .fail   (fail)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_letter(byte c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic int eff_depth();
        int d;
        if (m_f) return m_frozen;
        d = m_cd;
        if (m_w == "begin") d = d + 1;
        if (m_w == "end")   d = d - 1;
        return d;
    endfunction

    function automatic void model_reset();
        m_cd = 0;
        m_w = "";
        m_f = 1'b0;
        m_frozen = 0;
    endfunction

    function automatic void model_step(byte c);
        string nw;
        int d;
        if (m_f) return;
        if (is_letter(c)) begin
            nw = m_w;
            if (nw.len() < 6) begin
                nw = {nw, " "};
                nw.putc(nw.len() - 1, c | 8'h20);
            end else begin
                nw = "xxxxxx";
            end
            if (nw == "begin" && m_cd == D_MAX) begin
                m_f = 1'b1;
                m_frozen = m_cd;
            end
            m_w = nw;
        end else begin
            d = eff_depth();
            if (m_w == "end" && d < 0) begin
                m_f = 1'b1;
                m_frozen = d;
            end else begin
                m_cd = d;
            end
            m_w = "";
        end
    endfunction

    function automatic exp_t model_out(byte c);
        exp_t e;
        e.dep = eff_depth();
        e.fl  = m_f;
        e.res = (e.dep == 0) && !m_f;
        e.ch  = c;
        return e;
    endfunction

    task automatic push_char(byte c);
        din = c;
        model_step(c);
        sbq.push_back(model_out(c));
    endtask

    task automatic send(byte c);
        @(negedge clk);
        push_char(c);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s.getc(i));
    endtask

    task automatic check_idle(string tag);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL %s: result got %0b expected 1", tag, result);
        end
`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
        checks++;
        if (depth !== '0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL %s: depth/fail got %0d/%0b expected 0/0", tag, depth, fail);
        end
`endif
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge arrives.
    task automatic async_reset(string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        push_char(8'h20);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL result after char 0x%02h: got %0b expected %0b", e.ch, result, e.res);
            end
`ifdef BLOCK_CHECKER_DEPTH_OUT_EN
            checks++;
            if (depth !== DW'(e.dep) || fail !== e.fl) begin
                errors++;
                $display("FAIL depth/fail after char 0x%02h: got %0d/%0b expected %0d/%0b",
                         e.ch, depth, fail, e.dep, e.fl);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string words [10];
        byte   seps  [4];
        int    nw;
        words = '{"begin", "end", "BEGIN", "End", "beginx", "endd", "foo", "b", "be", "eNd"};
        seps  = '{8'h20, 8'h00, 8'h2E, 8'h0A};

        model_reset();
        #13;
        check_idle("reset_state");
        @(negedge clk);
        reset = 1'b0;
        push_char(8'h20);

        send_str("     ");
        send(8'h00);
        send_str("a begin begin end End");
        send_str(" ");
        async_reset("reset_1");

        send_str("BeGiNx eNd begin end");
        async_reset("reset_2");

        send_str("end begin");
        async_reset("reset_3");

        send_str("begin endd ");
        async_reset("reset_4");

        send_str("begin be");
        async_reset("reset_midword");
        send_str("end ");
        async_reset("reset_5");

        for (int i = 0; i < D_MAX + 2; i++) send_str("begin ");
        send_str("end end");
        async_reset("reset_sat");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) nw = $urandom_range(0, 2);
            else nw = $urandom_range(0, 9);
            send_str(words[nw]);
            send(seps[$urandom_range(0, 3)]);
            if ($urandom_range(0, 59) == 0) async_reset("reset_rand");
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_checker.md
Name: block_checker

Overview:
- Streaming checker for `begin`/`end` keyword balance in ASCII text, one character per clock.
- Words are separated by spaces; keyword matching is case-insensitive.
- `result` reports whether the characters received since reset form a balanced sequence:
  - every `end` closes an earlier open `begin`;
  - no `begin` is left open.
- Sits behind a byte-serial character source as a simple syntax monitor.

Parameters:
- DEPTH_W, 16: width of the signed nesting-depth counter; the positive limit is 2^(DEPTH_W-1)-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in, input, 8: ASCII character sampled on every rising edge.
- result, output, 1: 1 = balanced so far, 0 = unbalanced.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named `clk` and `reset`.
- Character classes:
  - Letter: 0x41-0x5A or 0x61-0x7A, compared case-insensitively.
  - Separator: every other byte, including 0x20 and 0x00.
- Word FSM states: SEP, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER. Reset and power-up state is SEP.
- Transitions on a letter:
  - SEP: `b` -> B, `e` -> E, other letter -> OTHER.
  - Along the keyword prefix chains (B -> BE -> BEG -> BEGI -> BEGIN and E -> EN -> END), the correct next letter advances one step; any other letter -> OTHER.
  - BEGIN, END and OTHER: any letter -> OTHER.
- Transitions on a separator: any state -> SEP.
- Depth counter (signed, DEPTH_W bits, reset 0), tentative update so `result` is correct the cycle a keyword completes:
  - Entering BEGIN: depth +1.
  - Leaving BEGIN on a letter (e.g. `beginx`): depth -1.
  - Entering END: depth -1.
  - Leaving END on a letter (e.g. `endx`): depth +1.
- Fail flag (reset 0), sticky until reset:
  - Set when END is left on a separator while depth < 0.
  - Once set, depth is frozen and the FSM keeps tracking words with no effect.
- Saturation: depth does not wrap. An increment at the positive limit holds the value and sets fail.
- Output: `result` = (depth == 0) && !fail, decoded from registered state.
  - Valid right after each rising edge; no added latency.
  - Reset value is 1 (the empty string is balanced).
- Reset mid-stream:
  - Immediately forces SEP, depth 0, fail 0 and result 1, independent of clk.
  - The first character after reset release starts a new word.
- A held byte value is consumed again on every edge; there is no valid/handshake signal.

Optional Feature:
- Macro: BLOCK_CHECKER_DEPTH_OUT_EN.
- When defined:
  - Adds output port `depth`, DEPTH_W bits, signed, driven directly by the depth counter.
  - Adds output port `fail`, 1 bit, the sticky fail flag.
  - Both reset to 0.
- When undefined: neither port exists. `result` behaviour is identical in both builds.

Test Plan:
- Reset released, no letters fed, only 0x20 -> result stays 1; depth 0.
- Stream "a begin begin end End", one char per cycle:
  - result=0 from the `n` of the first `begin`;
  - result stays 0 through `end` (depth 1);
  - result=1 on the final `d` (depth 0).
- Stream "BeGiNx eNd" -> depth back to 0 on `x`; result=0 after `d` (depth -1).
  - Then a space -> fail latched.
  - Then " begin end" -> result remains 0.
- Stream "end begin" -> result=0 after `d`; fail set on the following space; result stays 0 after `begin`.
- Stream "begin endd" -> result=1 after the first `d`; result=0 after the second `d` (depth 1).
- Assert reset asynchronously mid-word after "begin be" -> result=1 without a clock edge.
  - Then "end " -> result=0 and fail set.
